// File: rtl/cgra_ext_obi_xbar.sv
// ---------------------------------------------------------------------------
// cgra_ext_obi_xbar
//
// OBI crossbar between NMASTER CGRA column master ports and NSLAVE external
// slaves. Each slave has its own address window, its own round-robin arbiter
// with request locking, and its own FIFO of master indices. The FIFO routes
// in-order responses back to the master that issued them. Requests that hit
// no window are granted at once and get an error response one cycle later.
//
// Ports:
//   clk_i, rst_ni                      clock, synchronous active-low reset
//   m_req_i / m_gnt_o                  master request / grant
//   m_addr_i, m_we_i, m_be_i, m_wdata_i  master request payload (packed)
//   m_rvalid_o, m_rdata_o, m_err_o     master response
//   s_req_o / s_gnt_i                  slave request / grant
//   s_addr_o, s_we_o, s_be_o, s_wdata_o  forwarded request payload (packed)
//   s_rvalid_i, s_rdata_i              slave response, in order per slave
// ---------------------------------------------------------------------------
module cgra_ext_obi_xbar #(
    parameter int unsigned NMASTER   = 4,
    parameter int unsigned NSLAVE    = 2,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_OUTST = 2,
    parameter logic [NSLAVE*ADDR_W-1:0] SLV_START = {32'h2010_0000, 32'h2000_0000},
    parameter logic [NSLAVE*ADDR_W-1:0] SLV_END   = {32'h2020_0000, 32'h2010_0000}
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NMASTER-1:0]         m_req_i,
    output logic [NMASTER-1:0]         m_gnt_o,
    input  logic [NMASTER*ADDR_W-1:0]  m_addr_i,
    input  logic [NMASTER-1:0]         m_we_i,
    input  logic [NMASTER*DATA_W/8-1:0] m_be_i,
    input  logic [NMASTER*DATA_W-1:0]  m_wdata_i,
    output logic [NMASTER-1:0]         m_rvalid_o,
    output logic [NMASTER*DATA_W-1:0]  m_rdata_o,
    output logic [NMASTER-1:0]         m_err_o,
    output logic [NSLAVE-1:0]          s_req_o,
    input  logic [NSLAVE-1:0]          s_gnt_i,
    output logic [NSLAVE*ADDR_W-1:0]   s_addr_o,
    output logic [NSLAVE-1:0]          s_we_o,
    output logic [NSLAVE*DATA_W/8-1:0] s_be_o,
    output logic [NSLAVE*DATA_W-1:0]   s_wdata_o,
    input  logic [NSLAVE-1:0]          s_rvalid_i,
    input  logic [NSLAVE*DATA_W-1:0]   s_rdata_i
);

    localparam int unsigned BE_W   = DATA_W / 8;
    localparam int unsigned MIDX_W = (NMASTER > 1) ? $clog2(NMASTER) : 1;
    localparam int unsigned SIDX_W = (NSLAVE > 1) ? $clog2(NSLAVE) : 1;
    localparam int unsigned PTR_W  = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int unsigned OCC_W  = $clog2(MAX_OUTST + 1);
    localparam int unsigned CNT_W  = $clog2(NMASTER * MAX_OUTST + 1);

    // Per-master tracking: current target (slave index or error) and count
    logic [CNT_W-1:0]  cnt_q    [NMASTER];
    logic [SIDX_W-1:0] tgtIdx_q [NMASTER];
    logic [NMASTER-1:0] tgtErr_q;
    logic [NMASTER-1:0] errPend_q;

    // Per-slave arbitration state and response-routing FIFO
    logic [MIDX_W-1:0] rrPtr_q   [NSLAVE];
    logic [MIDX_W-1:0] lockIdx_q [NSLAVE];
    logic [NSLAVE-1:0] lockVld_q;
    logic [MIDX_W-1:0] fifoMem_q [NSLAVE][MAX_OUTST];
    logic [PTR_W-1:0]  wrPtr_q   [NSLAVE];
    logic [PTR_W-1:0]  rdPtr_q   [NSLAVE];
    logic [OCC_W-1:0]  occ_q     [NSLAVE];

    logic [NMASTER-1:0]              decHit;
    logic [SIDX_W-1:0]               decIdx [NMASTER];
    logic [NMASTER-1:0]              elig;
    logic [NMASTER-1:0]              errGnt;
    logic [NSLAVE-1:0][NMASTER-1:0]  cand;
    logic [NSLAVE-1:0]               lockHit;
    logic [NSLAVE-1:0]               sReq;
    logic [NSLAVE-1:0]               hs;
    logic [NSLAVE-1:0]               pop;
    logic [MIDX_W-1:0]               sel  [NSLAVE];
    logic [MIDX_W-1:0]               head [NSLAVE];
    logic [NMASTER-1:0]              cntInc;
    logic [NMASTER-1:0]              cntDec;

    // Address decode; scanning downwards lets the lowest matching window win.
    always_comb begin
        for (int m = 0; m < NMASTER; m++) begin
            decHit[m] = 1'b0;
            decIdx[m] = '0;
            for (int j = NSLAVE - 1; j >= 0; j--) begin
                if (m_addr_i[m*ADDR_W +: ADDR_W] >= SLV_START[j*ADDR_W +: ADDR_W] &&
                    m_addr_i[m*ADDR_W +: ADDR_W] <  SLV_END[j*ADDR_W +: ADDR_W]) begin
                    decHit[m] = 1'b1;
                    decIdx[m] = SIDX_W'(j);
                end
            end
        end
    end

    // A master with outstanding work may only issue more to the same target;
    // an error target never has more than one transaction in flight.
    always_comb begin
        cand = '0;
        for (int m = 0; m < NMASTER; m++) begin
            if (cnt_q[m] == '0) begin
                elig[m] = 1'b1;
            end else if (decHit[m]) begin
                elig[m] = !tgtErr_q[m] && (tgtIdx_q[m] == decIdx[m]);
            end else begin
                elig[m] = 1'b0;
            end
            errGnt[m] = m_req_i[m] && elig[m] && !decHit[m];
            for (int j = 0; j < NSLAVE; j++) begin
                cand[j][m] = m_req_i[m] && elig[m] && decHit[m] &&
                             (decIdx[m] == SIDX_W'(j));
            end
        end
    end

    // Per-slave arbiter: a locked master keeps the port; otherwise the first
    // candidate at or after the round-robin pointer wins.
    always_comb begin : arbComb
        int   idx;
        logic found;
        for (int j = 0; j < NSLAVE; j++) begin
            lockHit[j] = lockVld_q[j] && cand[j][lockIdx_q[j]];
            sel[j]     = lockIdx_q[j];
            head[j]    = fifoMem_q[j][rdPtr_q[j]];
            found      = 1'b0;
            idx        = 0;
            if (!lockHit[j]) begin
                sel[j] = '0;
                for (int k = 0; k < NMASTER; k++) begin
                    idx = int'(rrPtr_q[j]) + k;
                    if (idx >= int'(NMASTER)) begin
                        idx = idx - int'(NMASTER);
                    end
                    if (!found && cand[j][idx]) begin
                        found  = 1'b1;
                        sel[j] = MIDX_W'(idx);
                    end
                end
            end
            sReq[j] = (|cand[j]) && (occ_q[j] != OCC_W'(MAX_OUTST));
            hs[j]   = sReq[j] && s_gnt_i[j];
            pop[j]  = s_rvalid_i[j] && (occ_q[j] != '0);
        end
    end

    // Master-side outputs: grants, routed slave responses, error responses.
    always_comb begin
        m_gnt_o    = '0;
        m_rvalid_o = '0;
        m_err_o    = '0;
        m_rdata_o  = '0;
        cntInc     = errGnt;
        cntDec     = errPend_q;
        for (int j = 0; j < NSLAVE; j++) begin
            if (hs[j]) begin
                cntInc[sel[j]] = 1'b1;
            end
            if (pop[j]) begin
                cntDec[head[j]] = 1'b1;
            end
        end
        if (rst_ni) begin
            m_gnt_o = errGnt;
            for (int j = 0; j < NSLAVE; j++) begin
                if (hs[j]) begin
                    m_gnt_o[sel[j]] = 1'b1;
                end
                if (pop[j]) begin
                    m_rvalid_o[head[j]] = 1'b1;
                    m_rdata_o[int'(head[j])*DATA_W +: DATA_W] = s_rdata_i[j*DATA_W +: DATA_W];
                end
            end
            for (int m = 0; m < NMASTER; m++) begin
                if (errPend_q[m]) begin
                    m_rvalid_o[m] = 1'b1;
                    m_err_o[m]    = 1'b1;
                end
            end
        end
    end

    // Slave-side outputs: payload always follows the selected master.
    always_comb begin
        s_req_o   = '0;
        s_addr_o  = '0;
        s_we_o    = '0;
        s_be_o    = '0;
        s_wdata_o = '0;
        if (rst_ni) begin
            s_req_o = sReq;
            for (int j = 0; j < NSLAVE; j++) begin
                s_addr_o[j*ADDR_W +: ADDR_W] = m_addr_i[int'(sel[j])*ADDR_W +: ADDR_W];
                s_we_o[j]                    = m_we_i[sel[j]];
                s_be_o[j*BE_W +: BE_W]       = m_be_i[int'(sel[j])*BE_W +: BE_W];
                s_wdata_o[j*DATA_W +: DATA_W] = m_wdata_i[int'(sel[j])*DATA_W +: DATA_W];
            end
        end
    end

    // State update: master counters/targets, FIFOs, round-robin and locks.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tgtErr_q  <= '0;
            errPend_q <= '0;
            lockVld_q <= '0;
            for (int m = 0; m < NMASTER; m++) begin
                cnt_q[m]    <= '0;
                tgtIdx_q[m] <= '0;
            end
            for (int j = 0; j < NSLAVE; j++) begin
                rrPtr_q[j]   <= '0;
                lockIdx_q[j] <= '0;
                wrPtr_q[j]   <= '0;
                rdPtr_q[j]   <= '0;
                occ_q[j]     <= '0;
            end
        end else begin
            errPend_q <= errGnt;
            for (int m = 0; m < NMASTER; m++) begin
                cnt_q[m] <= cnt_q[m] + CNT_W'(cntInc[m]) - CNT_W'(cntDec[m]);
                if (errGnt[m]) begin
                    tgtErr_q[m] <= 1'b1;
                end
            end
            for (int j = 0; j < NSLAVE; j++) begin
                if (hs[j]) begin
                    tgtErr_q[sel[j]]          <= 1'b0;
                    tgtIdx_q[sel[j]]          <= SIDX_W'(j);
                    fifoMem_q[j][wrPtr_q[j]]  <= sel[j];
                    wrPtr_q[j] <= (wrPtr_q[j] == PTR_W'(MAX_OUTST - 1)) ? '0 : wrPtr_q[j] + 1'b1;
                    rrPtr_q[j] <= (sel[j] == MIDX_W'(NMASTER - 1)) ? '0 : sel[j] + 1'b1;
                end
                if (pop[j]) begin
                    rdPtr_q[j] <= (rdPtr_q[j] == PTR_W'(MAX_OUTST - 1)) ? '0 : rdPtr_q[j] + 1'b1;
                end
                occ_q[j] <= occ_q[j] + OCC_W'(hs[j]) - OCC_W'(pop[j]);
                // Hold the port for a master whose request is pending but not
                // yet granted; drop it if that master went away.
                if (hs[j]) begin
                    lockVld_q[j] <= 1'b0;
                end else if (sReq[j]) begin
                    lockVld_q[j] <= 1'b1;
                    lockIdx_q[j] <= sel[j];
                end else if (lockVld_q[j] && !lockHit[j]) begin
                    lockVld_q[j] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cgra_ext_obi_xbar.sv
// ---------------------------------------------------------------------------
// tb_cgra_ext_obi_xbar
//
// Directed bench for cgra_ext_obi_xbar with 4 masters, 2 slaves
// (slave 0 at 0x2000_0000..0x2010_0000, slave 1 at 0x2010_0000..0x2020_0000)
// and two outstanding transactions per slave. Inputs change 1 time unit after
// a rising edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_cgra_ext_obi_xbar;

    localparam int NM = 4;
    localparam int NS = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic [NM-1:0]     m_req_i;
    logic [NM-1:0]     m_gnt_o;
    logic [NM*AW-1:0]  m_addr_i;
    logic [NM-1:0]     m_we_i;
    logic [NM*DW/8-1:0] m_be_i;
    logic [NM*DW-1:0]  m_wdata_i;
    logic [NM-1:0]     m_rvalid_o;
    logic [NM*DW-1:0]  m_rdata_o;
    logic [NM-1:0]     m_err_o;
    logic [NS-1:0]     s_req_o;
    logic [NS-1:0]     s_gnt_i;
    logic [NS*AW-1:0]  s_addr_o;
    logic [NS-1:0]     s_we_o;
    logic [NS*DW/8-1:0] s_be_o;
    logic [NS*DW-1:0]  s_wdata_o;
    logic [NS-1:0]     s_rvalid_i;
    logic [NS*DW-1:0]  s_rdata_i;

    int checks;
    int failures;

    cgra_ext_obi_xbar dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .m_req_i    (m_req_i),
        .m_gnt_o    (m_gnt_o),
        .m_addr_i   (m_addr_i),
        .m_we_i     (m_we_i),
        .m_be_i     (m_be_i),
        .m_wdata_i  (m_wdata_i),
        .m_rvalid_o (m_rvalid_o),
        .m_rdata_o  (m_rdata_o),
        .m_err_o    (m_err_o),
        .s_req_o    (s_req_o),
        .s_gnt_i    (s_gnt_i),
        .s_addr_o   (s_addr_o),
        .s_we_o     (s_we_o),
        .s_be_o     (s_be_o),
        .s_wdata_o  (s_wdata_o),
        .s_rvalid_i (s_rvalid_i),
        .s_rdata_i  (s_rdata_i)
    );

    // Free-running clock, period 10
    always #5 clk_i = ~clk_i;

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        m_req_i    = '0;
        m_addr_i   = '0;
        m_we_i     = '0;
        m_be_i     = '0;
        m_wdata_i  = '0;
        s_gnt_i    = '0;
        s_rvalid_i = '0;
        s_rdata_i  = '0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        idle();
        tick();
        tick();
        rst_ni = 1'b1;
    endtask

    task automatic drive_master(input int m, input logic [31:0] addr, input logic we);
        m_req_i[m]            = 1'b1;
        m_addr_i[m*AW +: AW]  = addr;
        m_we_i[m]             = we;
        m_be_i[m*4 +: 4]      = 4'hF;
        m_wdata_i[m*DW +: DW] = 32'hD000_0000 + 32'(m);
    endtask

    // Outputs are forced low while reset is held, even with active inputs
    task automatic test_reset();
        rst_ni = 1'b0;
        idle();
        for (int m = 0; m < NM; m++) drive_master(m, 32'h2000_0100, 1'b1);
        s_gnt_i    = 2'b11;
        s_rvalid_i = 2'b11;
        s_rdata_i  = {32'h1111_1111, 32'h2222_2222};
        @(negedge clk_i);
        checks++;
        if (m_gnt_o !== 4'b0000) begin failures++; $display("[TB] FAIL reset_m_gnt: got %b want %b", m_gnt_o, 4'b0000); end
        checks++;
        if (s_req_o !== 2'b00) begin failures++; $display("[TB] FAIL reset_s_req: got %b want %b", s_req_o, 2'b00); end
        checks++;
        if (m_rvalid_o !== 4'b0000 || m_err_o !== 4'b0000) begin failures++; $display("[TB] FAIL reset_m_resp: got rvalid=%b err=%b want 0000/0000", m_rvalid_o, m_err_o); end
        checks++;
        if (s_addr_o !== '0 || s_we_o !== '0 || s_be_o !== '0 || s_wdata_o !== '0 || m_rdata_o !== '0) begin
            failures++; $display("[TB] FAIL reset_payload: got addr=%h we=%b be=%h rdata=%h want all zero", s_addr_o, s_we_o, s_be_o, m_rdata_o);
        end
        tick();
        rst_ni = 1'b1;
        idle();
        s_rvalid_i = 2'b11;
        @(negedge clk_i);
        checks++;
        if (m_rvalid_o !== 4'b0000 || s_req_o !== 2'b00) begin failures++; $display("[TB] FAIL reset_after_release: got rvalid=%b s_req=%b want 0000/00", m_rvalid_o, s_req_o); end
        tick();
    endtask

    // Single read from M0 to slave 0, response two cycles after the grant
    task automatic test_single_read();
        do_reset();
        drive_master(0, 32'h2000_0010, 1'b0);
        s_gnt_i = 2'b11;
        @(negedge clk_i);
        checks++;
        if (s_req_o !== 2'b01) begin failures++; $display("[TB] FAIL single_s_req: got %b want %b", s_req_o, 2'b01); end
        checks++;
        if (m_gnt_o !== 4'b0001) begin failures++; $display("[TB] FAIL single_m_gnt: got %b want %b", m_gnt_o, 4'b0001); end
        checks++;
        if (s_addr_o[31:0] !== 32'h2000_0010 || s_we_o[0] !== 1'b0 || s_be_o[3:0] !== 4'hF) begin
            failures++; $display("[TB] FAIL single_payload: got addr=%h we=%b be=%h want 20000010/0/f", s_addr_o[31:0], s_we_o[0], s_be_o[3:0]);
        end
        tick();
        m_req_i = '0;
        @(negedge clk_i);
        checks++;
        if (m_rvalid_o !== 4'b0000) begin failures++; $display("[TB] FAIL single_early_rvalid: got %b want %b", m_rvalid_o, 4'b0000); end
        tick();
        s_rvalid_i = 2'b01;
        s_rdata_i[31:0] = 32'hCAFE_F00D;
        @(negedge clk_i);
        checks++;
        if (m_rvalid_o !== 4'b0001 || m_err_o !== 4'b0000) begin failures++; $display("[TB] FAIL single_rvalid: got rvalid=%b err=%b want 0001/0000", m_rvalid_o, m_err_o); end
        checks++;
        if (m_rdata_o[31:0] !== 32'hCAFE_F00D) begin failures++; $display("[TB] FAIL single_rdata: got %h want %h", m_rdata_o[31:0], 32'hCAFE_F00D); end
        tick();
        // FIFO is empty now; a stray response must be dropped
        @(negedge clk_i);
        checks++;
        if (m_rvalid_o !== 4'b0000) begin failures++; $display("[TB] FAIL single_stray_rvalid: got %b want %b", m_rvalid_o, 4'b0000); end
        tick();
        idle();
    endtask

    // All masters hammer slave 0; slave answers every cycle after the first
    task automatic test_round_robin();
        int order [6] = '{0, 1, 2, 3, 0, 1};
        logic [3:0] expG;
        logic [3:0] expV;
        do_reset();
        for (int m = 0; m < NM; m++) drive_master(m, 32'h2000_0000 + 32'(m * 4), 1'b0);
        s_gnt_i = 2'b11;
        for (int c = 0; c < 6; c++) begin
            s_rvalid_i = (c > 0) ? 2'b01 : 2'b00;
            s_rdata_i[31:0] = 32'h1000_0000 + 32'(c);
            expG = 4'b0001 << order[c];
            expV = (c > 0) ? (4'b0001 << order[(c > 0) ? c - 1 : 0]) : 4'b0000;
            @(negedge clk_i);
            checks++;
            if (m_gnt_o !== expG) begin failures++; $display("[TB] FAIL rr_gnt_c%0d: got %b want %b", c, m_gnt_o, expG); end
            checks++;
            if (m_rvalid_o !== expV) begin failures++; $display("[TB] FAIL rr_rvalid_c%0d: got %b want %b", c, m_rvalid_o, expV); end
            if (c > 0) begin
                checks++;
                if (m_rdata_o[order[c-1]*DW +: DW] !== 32'h1000_0000 + 32'(c)) begin
                    failures++; $display("[TB] FAIL rr_rdata_c%0d: got %h want %h", c, m_rdata_o[order[c-1]*DW +: DW], 32'h1000_0000 + 32'(c));
                end
            end
            tick();
        end
        idle();
    endtask

    // Slave 1 stalls; the first-presented master (M2) keeps the port
    task automatic test_lock();
        do_reset();
        drive_master(2, 32'h2010_0020, 1'b1);
        for (int c = 0; c < 3; c++) begin
            if (c == 1) drive_master(1, 32'h2010_0040, 1'b0);
            @(negedge clk_i);
            checks++;
            if (s_req_o !== 2'b10 || s_addr_o[63:32] !== 32'h2010_0020 || s_wdata_o[63:32] !== 32'hD000_0002) begin
                failures++; $display("[TB] FAIL lock_hold_c%0d: got s_req=%b addr=%h wdata=%h want 10/20100020/d0000002", c, s_req_o, s_addr_o[63:32], s_wdata_o[63:32]);
            end
            checks++;
            if (m_gnt_o !== 4'b0000) begin failures++; $display("[TB] FAIL lock_nogrant_c%0d: got %b want %b", c, m_gnt_o, 4'b0000); end
            tick();
        end
        s_gnt_i = 2'b10;
        @(negedge clk_i);
        checks++;
        if (m_gnt_o !== 4'b0100) begin failures++; $display("[TB] FAIL lock_grant_m2: got %b want %b", m_gnt_o, 4'b0100); end
        tick();
        m_req_i[2] = 1'b0;
        @(negedge clk_i);
        checks++;
        if (m_gnt_o !== 4'b0010 || s_addr_o[63:32] !== 32'h2010_0040) begin
            failures++; $display("[TB] FAIL lock_grant_m1: got gnt=%b addr=%h want 0010/20100040", m_gnt_o, s_addr_o[63:32]);
        end
        tick();
        idle();
    endtask

    // FIFO depth 2 bounds outstanding reads; one response frees a slot
    task automatic test_outstanding();
        logic [3:0] expG [3] = '{4'b0001, 4'b0001, 4'b0000};
        logic [1:0] expR [3] = '{2'b01, 2'b01, 2'b00};
        do_reset();
        drive_master(0, 32'h2000_0200, 1'b0);
        s_gnt_i = 2'b11;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            checks++;
            if (m_gnt_o !== expG[c] || s_req_o !== expR[c]) begin
                failures++; $display("[TB] FAIL outst_c%0d: got gnt=%b s_req=%b want %b/%b", c, m_gnt_o, s_req_o, expG[c], expR[c]);
            end
            tick();
        end
        s_rvalid_i = 2'b01;
        @(negedge clk_i);
        checks++;
        if (m_gnt_o !== 4'b0000 || s_req_o !== 2'b00 || m_rvalid_o !== 4'b0001) begin
            failures++; $display("[TB] FAIL outst_pop_cycle: got gnt=%b s_req=%b rvalid=%b want 0000/00/0001", m_gnt_o, s_req_o, m_rvalid_o);
        end
        tick();
        s_rvalid_i = 2'b00;
        @(negedge clk_i);
        checks++;
        if (m_gnt_o !== 4'b0001 || s_req_o !== 2'b01) begin
            failures++; $display("[TB] FAIL outst_release: got gnt=%b s_req=%b want 0001/01", m_gnt_o, s_req_o);
        end
        tick();
        idle();
    endtask

    // Unmapped write from M3: immediate grant, error one cycle later
    task automatic test_unmapped();
        do_reset();
        s_gnt_i = 2'b11;
        drive_master(3, 32'h3000_0000, 1'b1);
        @(negedge clk_i);
        checks++;
        if (m_gnt_o !== 4'b1000 || s_req_o !== 2'b00 || m_rvalid_o !== 4'b0000) begin
            failures++; $display("[TB] FAIL unmap_gnt: got gnt=%b s_req=%b rvalid=%b want 1000/00/0000", m_gnt_o, s_req_o, m_rvalid_o);
        end
        tick();
        // Second unmapped request must wait for the pending error
        @(negedge clk_i);
        checks++;
        if (m_rvalid_o !== 4'b1000 || m_err_o !== 4'b1000 || m_rdata_o[3*DW +: DW] !== 32'h0) begin
            failures++; $display("[TB] FAIL unmap_err: got rvalid=%b err=%b rdata=%h want 1000/1000/00000000", m_rvalid_o, m_err_o, m_rdata_o[3*DW +: DW]);
        end
        checks++;
        if (m_gnt_o !== 4'b0000 || s_req_o !== 2'b00) begin failures++; $display("[TB] FAIL unmap_stall: got gnt=%b s_req=%b want 0000/00", m_gnt_o, s_req_o); end
        tick();
        @(negedge clk_i);
        checks++;
        if (m_gnt_o !== 4'b1000 || m_rvalid_o !== 4'b0000) begin failures++; $display("[TB] FAIL unmap_regrant: got gnt=%b rvalid=%b want 1000/0000", m_gnt_o, m_rvalid_o); end
        tick();
        m_req_i = '0;
        @(negedge clk_i);
        checks++;
        if (m_rvalid_o !== 4'b1000 || m_err_o !== 4'b1000) begin failures++; $display("[TB] FAIL unmap_err2: got rvalid=%b err=%b want 1000/1000", m_rvalid_o, m_err_o); end
        tick();
        idle();
    endtask

    // Target switch stalls until the old slave answers; reset drops in-flight work
    task automatic test_in_order_reset();
        do_reset();
        s_gnt_i = 2'b11;
        drive_master(0, 32'h2000_0040, 1'b0);
        @(negedge clk_i);
        checks++;
        if (m_gnt_o !== 4'b0001) begin failures++; $display("[TB] FAIL order_first_gnt: got %b want %b", m_gnt_o, 4'b0001); end
        tick();
        drive_master(0, 32'h2010_0000, 1'b0);
        @(negedge clk_i);
        checks++;
        if (m_gnt_o !== 4'b0000 || s_req_o !== 2'b00) begin failures++; $display("[TB] FAIL order_stall: got gnt=%b s_req=%b want 0000/00", m_gnt_o, s_req_o); end
        tick();
        s_rvalid_i = 2'b01;
        s_rdata_i[31:0] = 32'h0BAD_CAFE;
        @(negedge clk_i);
        checks++;
        if (m_gnt_o !== 4'b0000 || m_rvalid_o !== 4'b0001 || m_rdata_o[31:0] !== 32'h0BAD_CAFE) begin
            failures++; $display("[TB] FAIL order_resp: got gnt=%b rvalid=%b rdata=%h want 0000/0001/0badcafe", m_gnt_o, m_rvalid_o, m_rdata_o[31:0]);
        end
        tick();
        s_rvalid_i = 2'b00;
        @(negedge clk_i);
        checks++;
        if (m_gnt_o !== 4'b0001 || s_req_o !== 2'b10 || s_addr_o[63:32] !== 32'h2010_0000) begin
            failures++; $display("[TB] FAIL order_switch: got gnt=%b s_req=%b addr=%h want 0001/10/20100000", m_gnt_o, s_req_o, s_addr_o[63:32]);
        end
        tick();
        m_req_i = '0;
        rst_ni  = 1'b0;
        tick();
        rst_ni = 1'b1;
        tick();
        s_rvalid_i = 2'b10;
        s_rdata_i[63:32] = 32'h5555_AAAA;
        @(negedge clk_i);
        checks++;
        if (m_rvalid_o !== 4'b0000 || m_err_o !== 4'b0000) begin
            failures++; $display("[TB] FAIL reset_drop_rvalid: got rvalid=%b err=%b want 0000/0000", m_rvalid_o, m_err_o);
        end
        tick();
        idle();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_ni   = 1'b0;
        idle();
        tick();
        test_reset();
        test_single_read();
        test_round_robin();
        test_lock();
        test_outstanding();
        test_unmapped();
        test_in_order_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cgra_ext_obi_xbar.md
Name: cgra_ext_obi_xbar

Overview:
Parametrised N-master/M-slave OBI crossbar for the CGRA external bus. It generalises the fixed 4-column, single-context-memory slave map to configurable master and slave counts and per-slave address windows. It adds per-slave round-robin arbitration, request locking, in-order response routing with bounded outstanding transactions, and error responses for unmapped addresses. It sits between the CGRA column master ports and the external-slave side of the MCU.

Parameters:
NMASTER, 4, number of master ports (one per CGRA column), >=1
NSLAVE, 2, number of slave ports, >=1
ADDR_W, 32, address width
DATA_W, 32, data width; BE width = DATA_W/8
MAX_OUTST, 2, per-slave outstanding-transaction FIFO depth, >=1, power of two
SLV_START, {NSLAVE{ADDR_W}} packed, per-slave window start, inclusive
SLV_END, {NSLAVE{ADDR_W}} packed, per-slave window end, exclusive

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
m_req_i  in  NMASTER  master request
m_gnt_o  out  NMASTER  master grant
m_addr_i  in  NMASTER*ADDR_W  master address
m_we_i  in  NMASTER  write enable
m_be_i  in  NMASTER*DATA_W/8  byte enables
m_wdata_i  in  NMASTER*DATA_W  write data
m_rvalid_o  out  NMASTER  response valid
m_rdata_o  out  NMASTER*DATA_W  response data
m_err_o  out  NMASTER  response error
s_req_o  out  NSLAVE  slave request
s_gnt_i  in  NSLAVE  slave grant
s_addr_o  out  NSLAVE*ADDR_W  forwarded address
s_we_o  out  NSLAVE  forwarded write enable
s_be_o  out  NSLAVE*DATA_W/8  forwarded byte enables
s_wdata_o  out  NSLAVE*DATA_W  forwarded write data
s_rvalid_i  in  NSLAVE  slave response valid, in order per slave
s_rdata_i  in  NSLAVE*DATA_W  slave response data

Behaviour:
- Reset: all FIFOs empty, RR pointers = 0, locks clear, error-pending clear. While rst_ni=0, m_gnt_o, m_rvalid_o, m_err_o, s_req_o are forced to 0, and m_rdata_o, s_addr_o, s_we_o, s_be_o, s_wdata_o are forced to 0.
- Decode (combinational): master targets slave j if SLV_START[j] <= addr < SLV_END[j]. On overlapping windows, the lowest j wins. No match means unmapped.
- Master eligibility: each master tracks tgt (slave index or ERR) and cnt (0..NMASTER*MAX_OUTST).
  - If cnt>0 and the decoded target differs from tgt, the master is stalled: it is not presented to any arbiter and gets no gnt.
  - This guarantees in-order responses per master.
- Arbitration per slave j:
  - Candidates are eligible masters decoding to j.
  - If lock[j] is set, the locked master is selected.
  - Otherwise the first candidate at or after rr[j], wrapping modulo NMASTER, is selected.
  - s_req_o[j] = candidate exists AND FIFO[j] not full. Payload is muxed from the selected master. m_gnt_o[sel] = s_gnt_i[j] & s_req_o[j].
- Lock: if s_req_o[j]=1 and s_gnt_i[j]=0, set lock[j] to sel. Clear it on handshake. If the locked master drops req (protocol violation), clear the lock with no other effect.
- On handshake at slave j:
  - Push the master index into FIFO[j].
  - rr[j] <= sel+1 mod NMASTER.
  - Master cnt++ and tgt <= j.
- Response: s_rvalid_i[j] pops FIFO[j] and drives m_rvalid_o[head]=1 with rdata = s_rdata_i[j] and err=0, in the same cycle (combinational, zero latency). That master's cnt--.
  - Push and pop in the same cycle: FIFO occupancy unchanged.
  - s_rvalid_i on an empty FIFO is ignored; no master response.
- Unmapped request: an eligible master gets m_gnt_o=1 in the same cycle. The next cycle it gets m_rvalid_o=1, m_err_o=1, rdata=0. Reads and writes are treated identically.
  - Only one error response is pending per master, so cnt<=1 for ERR. A new unmapped request is stalled until the pending one retires.
- Simultaneous responses from different slaves target distinct masters by construction, so no collision is possible.
- cnt saturates by construction: each FIFO is bounded at MAX_OUTST, and gnt is withheld when the FIFO is full.
- Reset mid-transaction: all in-flight state is dropped. Responses that arrive after reset release are ignored, because the FIFOs are empty.

Test Plan:
- NMASTER=4, NSLAVE=2, SLV_START={0x20100000,0x20000000}, SLV_END={0x20200000,0x20100000}. M0 reads 0x20000010 with s_gnt=1 → s_req_o[0]=1 and m_gnt_o[0]=1 in the same cycle. s_rvalid[0] with rdata=0xCAFEF00D two cycles later → m_rvalid_o[0]=1, rdata=0xCAFEF00D, err=0.
- All 4 masters request slave 0 continuously, s_gnt=1 → grant order M0,M1,M2,M3,M0. rr[0] returns to 1 after five grants.
- M2 requests slave 1 while s_gnt[1]=0 for 3 cycles, and M1 also requests slave 1 → s_req/addr stay on M2 all 3 cycles. M2 is granted on cycle 4, then M1.
- MAX_OUTST=2 with no slave responses: M0 issues 3 back-to-back reads to slave 0 → 2 grants, the third is held with s_req_o[0]=0. One s_rvalid releases it the next cycle.
- M3 writes to unmapped 0x30000000 → m_gnt_o[3]=1 in cycle 0. Cycle 1 gives m_rvalid_o[3]=1, m_err_o[3]=1, rdata=0, and no s_req_o is asserted.
- M0 has 1 outstanding to slave 0 and then requests slave 1 → m_gnt_o[0]=0 until the slave-0 response returns, then it is granted on slave 1. Asserting rst_ni=0 mid-transfer clears the FIFOs, and a later s_rvalid produces no m_rvalid_o.
